udp_txbuf_ctrl: RTL
===================

// Module: udp_txbuf_ctrl
// PURPOSE
//  - CPU-side owner of the ros2_ether UDP transmit buffer; sits directly upstream of the ros2_ether udp_txbuf_* port.
//  - Takes a header (dst IP, ports, length) plus a byte stream from a local producer.
//  - Packs them into a 32-bit word RAM in txbuf layout, releases the buffer to ros2_ether and tracks the grant handshake.
//  - Replaces the hard-coded txbuf_rdata case table and tx_cnt release counter in the top level.
// PARAMETERS
//  - AWIDTH  6        txbuf word-address width; RAM depth 2**AWIDTH words (matches UDP_TXBUF_AWIDTH).
//  - MAX_LEN derived  max payload bytes = (2**AWIDTH-3)*4, i.e. 244 at default.
//  - PERIOD  2**27    resend interval in clk cycles; used only with UDP_TXBUF_PERIODIC_EN.
// PORTS
//  - clk              in   1       system clock (clk_int domain)
//  - rst              in   1       asynchronous reset, active-high
//  - s_hdr_valid      in   1       header valid
//  - s_hdr_ready      out  1       header accepted this cycle
//  - s_dst_ip         in   32      destination IP; first octet in [7:0]
//  - s_dst_port       in   16      destination UDP port
//  - s_src_port       in   16      source UDP port
//  - s_len            in   16      payload length in bytes
//  - s_data_valid     in   1       payload byte valid
//  - s_data_ready     out  1       payload byte accepted
//  - s_data           in   8       payload byte
//  - s_data_last      in   1       producer's end-of-message marker (checked only)
//  - err_len          out  1       1-cycle pulse: s_len > MAX_LEN, header rejected
//  - err_last         out  1       1-cycle pulse: s_data_last disagrees with byte count
//  - busy             out  1       state != IDLE
//  - sent_cnt         out  16      count of completed release/grant round trips (wraps)
//  - txbuf_cpu_grant  in   1       level: 1 = CPU side owns buffer
//  - txbuf_cpu_rel    out  1       1-cycle pulse: hand buffer to ros2_ether
//  - txbuf_addr       in   AWIDTH  ros2_ether read word address
//  - txbuf_ce         in   1       ros2_ether read enable
//  - txbuf_rdata      out  32      read data, registered
// BEHAVIOUR
//  - Reset (async, rst=1): state IDLE; s_hdr_ready, s_data_ready, err_*, txbuf_cpu_rel, busy = 0; sent_cnt = 0; txbuf_rdata = 0; stored = 0; RAM contents not cleared.
//  - Layout (little-endian byte packing):
//    - word0 = dst_ip; word1 = {dst_port, src_port}; word2 = {16'h0, len}.
//    - Payload byte i lands in word 3+i/4, bits [8*(i%4)+:8].
//    - Unused bytes of the final word are written 0.
//  - Read port: when txbuf_ce=1, txbuf_rdata <= ram[txbuf_addr] on the next edge (1-cycle latency); otherwise txbuf_rdata holds.
//  - FSM IDLE:
//    - s_hdr_ready = txbuf_cpu_grant.
//    - On a handshake with s_len <= MAX_LEN: write words 0-2 (one per cycle, HDR state, 3 cycles), then go to LOAD, or to RELEASE if s_len = 0.
//    - On a handshake with s_len > MAX_LEN: pulse err_len, stay in IDLE, RAM untouched.
//  - FSM LOAD:
//    - s_data_ready = 1; bytes accumulate in a 32-bit shift/pack register.
//    - The word is written on the 4th byte or on the byte where count == len; then go to RELEASE.
//    - err_last pulses if s_data_last=1 with count < len, or s_data_last=0 on byte len. The message still ends at len.
//  - FSM RELEASE: txbuf_cpu_rel = 1 for exactly one cycle; set stored = 1; go to WAIT_DROP.
//  - FSM WAIT_DROP: wait for txbuf_cpu_grant = 0, then go to WAIT_GRANT.
//  - FSM WAIT_GRANT: wait for txbuf_cpu_grant = 1, then sent_cnt++ and go to IDLE.
//  - Header presented while not IDLE: s_hdr_ready stays 0 (producer stalls); no queuing.
//  - Grant already low in IDLE: header not accepted until grant returns.
//  - Address arithmetic: word pointer is AWIDTH bits; MAX_LEN guarantees no wrap; byte count is 16 bits.
//  - Mid-operation reset aborts the message; no rel pulse is emitted.
// CONFIGURATION
//  - UDP_TXBUF_PERIODIC_EN defined:
//    - In IDLE with stored=1, a PERIOD counter runs; at terminal count go to RELEASE and resend the unchanged buffer.
//    - The counter clears on every rel pulse and on any header handshake.
//  - UDP_TXBUF_PERIODIC_EN undefined: no counter logic; a release happens only after a new message.
// STRUCTURE
//  - Shared package/header: UDP_TXBUF_AWIDTH, word index constants (WIDX_IP=0, WIDX_PORT=1, WIDX_LEN=2, WIDX_PAYLOAD=3), FSM state encoding.
//  - One sub-module: udp_txbuf_ram (1 write port, 1 registered read port, 2**AWIDTH x 32).
//  - FSM, packer and counters stay in udp_txbuf_ctrl.
// TESTING
//  - "foobar\n" to 192.168.1.10, dst 1111, src 1234, grant=1
//    -> words 0..4 = 0a01a8c0, 045704d2, 00000007, 626f6f66, 000a7261.
//    -> one rel pulse.
//  - Drop grant 2 cycles after rel, raise it 10 cycles later
//    -> sent_cnt = 1, back in IDLE.
//    -> a header offered during the wait sees s_hdr_ready = 0 until grant returns.
//  - s_len = 245 at AWIDTH = 6 -> err_len pulse, no RAM write, no rel.
//  - s_len = 4 with s_data_last on byte 2 -> err_last pulse; 4 bytes are still taken; word3 complete.
//  - s_len = 0 -> only words 0-2 written; rel 4 cycles after the header handshake.
//  - Assert rst during LOAD -> all outputs at reset values next cycle.
//  - UDP_TXBUF_PERIODIC_EN with PERIOD = 100 -> rel every ~100 idle cycles; buffer contents identical.

Source files
------------

// File: rtl/udp_txbuf_pkg.sv
// Shared constants for the UDP transmit-buffer controller: buffer geometry,
// txbuf word layout, FSM state encoding and the header bundle.
package udp_txbuf_pkg;

  localparam int UDP_TXBUF_AWIDTH = 6;

  // txbuf word layout
  localparam int WIDX_IP      = 0;
  localparam int WIDX_PORT    = 1;
  localparam int WIDX_LEN     = 2;
  localparam int WIDX_PAYLOAD = 3;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_HDR    = 3'd1;
  localparam logic [2:0] ST_LOAD   = 3'd2;
  localparam logic [2:0] ST_REL    = 3'd3;
  localparam logic [2:0] ST_WDROP  = 3'd4;
  localparam logic [2:0] ST_WGRANT = 3'd5;

  typedef struct packed {
    logic [31:0] ip;
    logic [15:0] dst_port;
    logic [15:0] src_port;
    logic [15:0] len;
  } hdr_t;

  // Largest payload that fits after the three header words.
  function automatic logic [15:0] max_len(input int aw);
    return 16'(((1 << aw) - WIDX_PAYLOAD) * 4);
  endfunction

endpackage

// File: rtl/udp_txbuf_ram.sv
// 2**AWIDTH x 32 buffer RAM: one write port, one registered read port.
// Contents are not reset; only the read register is.
module udp_txbuf_ram #(
  parameter int AWIDTH = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AWIDTH-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic              re,
  input  logic [AWIDTH-1:0] raddr,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**AWIDTH];

  // write port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // registered read, holds when not enabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/udp_txbuf_ctrl.sv
// CPU-side owner of the ros2_ether UDP transmit buffer. Accepts a header and
// a byte stream, packs them into the txbuf word layout, releases the buffer
// and tracks the grant round trip.
// Optional feature macro: UDP_TXBUF_PERIODIC_EN (periodic resend of the
// stored buffer every PERIOD idle cycles).
module udp_txbuf_ctrl
  import udp_txbuf_pkg::*;
#(
  parameter int AWIDTH = UDP_TXBUF_AWIDTH,
  parameter int PERIOD = 2**27
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_hdr_valid,
  output logic              s_hdr_ready,
  input  logic [31:0]       s_dst_ip,
  input  logic [15:0]       s_dst_port,
  input  logic [15:0]       s_src_port,
  input  logic [15:0]       s_len,
  input  logic              s_data_valid,
  output logic              s_data_ready,
  input  logic [7:0]        s_data,
  input  logic              s_data_last,
  output logic              err_len,
  output logic              err_last,
  output logic              busy,
  output logic [15:0]       sent_cnt,
  input  logic              txbuf_cpu_grant,
  output logic              txbuf_cpu_rel,
  input  logic [AWIDTH-1:0] txbuf_addr,
  input  logic              txbuf_ce,
  output logic [31:0]       txbuf_rdata
);

  localparam logic [15:0] MAX_LEN = max_len(AWIDTH);

  logic [2:0]        state;
  hdr_t              hdr;
  logic [1:0]        hdr_idx;
  logic [15:0]       byte_cnt;
  logic [31:0]       pack;
  logic [AWIDTH-1:0] wptr;

  logic              hs, len_ok, byte_hs, at_end, word_done;
  logic [15:0]       cnt_nxt;
  logic [31:0]       merged;
  logic              ram_we;
  logic [AWIDTH-1:0] ram_waddr;
  logic [31:0]       ram_wdata;

`ifdef UDP_TXBUF_PERIODIC_EN
  logic              stored;
  logic [31:0]       per_cnt;
  logic              per_fire;
`endif

  // Ready is gated by reset so the producer never sees a handshake while
  // the block is held in reset.
  assign s_hdr_ready   = (state == ST_IDLE) & txbuf_cpu_grant & ~rst;
  assign s_data_ready  = (state == ST_LOAD);
  assign txbuf_cpu_rel = (state == ST_REL);
  assign busy          = (state != ST_IDLE);

  assign hs        = s_hdr_valid & s_hdr_ready;
  assign len_ok    = (s_len <= MAX_LEN);
  assign byte_hs   = s_data_valid & s_data_ready;
  assign cnt_nxt   = byte_cnt + 16'd1;
  assign at_end    = (cnt_nxt == hdr.len);
  assign word_done = (byte_cnt[1:0] == 2'd3) | at_end;

  // current pack register with the incoming byte merged at its lane
  always_comb begin
    merged = pack;
    merged[{byte_cnt[1:0], 3'b000} +: 8] = s_data;
  end

  // RAM write mux: header words during HDR, packed payload words during LOAD
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = wptr;
    ram_wdata = merged;
    case (state)
      ST_HDR: begin
        ram_we    = 1'b1;
        ram_waddr = AWIDTH'(hdr_idx);
        case (int'(hdr_idx))
          WIDX_IP:   ram_wdata = hdr.ip;
          WIDX_PORT: ram_wdata = {hdr.dst_port, hdr.src_port};
          default:   ram_wdata = {16'h0, hdr.len};
        endcase
      end
      ST_LOAD: ram_we = byte_hs & word_done;
      default: ram_we = 1'b0;
    endcase
  end

`ifdef UDP_TXBUF_PERIODIC_EN
  assign per_fire = (state == ST_IDLE) & stored & (per_cnt == 32'(PERIOD - 1));

  // resend timer: runs only while idle with a buffer already released once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stored  <= 1'b0;
      per_cnt <= '0;
    end else begin
      if (state == ST_REL) stored <= 1'b1;
      if ((state == ST_REL) || hs)       per_cnt <= '0;
      else if ((state == ST_IDLE) && stored) per_cnt <= per_cnt + 32'd1;
    end
  end
`endif

  // main FSM, payload packer, error pulses and round-trip counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      hdr      <= '0;
      hdr_idx  <= '0;
      byte_cnt <= '0;
      pack     <= '0;
      wptr     <= '0;
      sent_cnt <= '0;
      err_len  <= 1'b0;
      err_last <= 1'b0;
    end else begin
      err_len  <= 1'b0;
      err_last <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (hs) begin
            if (len_ok) begin
              hdr     <= '{ip: s_dst_ip, dst_port: s_dst_port,
                           src_port: s_src_port, len: s_len};
              hdr_idx <= '0;
              state   <= ST_HDR;
            end else begin
              err_len <= 1'b1;
            end
          end
`ifdef UDP_TXBUF_PERIODIC_EN
          else if (per_fire) state <= ST_REL;
`endif
        end
        ST_HDR: begin
          hdr_idx <= hdr_idx + 2'd1;
          if (hdr_idx == 2'(WIDX_LEN)) begin
            byte_cnt <= '0;
            pack     <= '0;
            wptr     <= AWIDTH'(WIDX_PAYLOAD);
            state    <= (hdr.len == 16'd0) ? ST_REL : ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (byte_hs) begin
            byte_cnt <= cnt_nxt;
            // clearing after each write keeps unused tail bytes at zero
            pack     <= word_done ? '0 : merged;
            if (word_done) wptr <= wptr + AWIDTH'(1);
            if (at_end ? ~s_data_last : s_data_last) err_last <= 1'b1;
            if (at_end) state <= ST_REL;
          end
        end
        ST_REL:    state <= ST_WDROP;
        ST_WDROP:  if (!txbuf_cpu_grant) state <= ST_WGRANT;
        ST_WGRANT: begin
          if (txbuf_cpu_grant) begin
            sent_cnt <= sent_cnt + 16'd1;
            state    <= ST_IDLE;
          end
        end
        default:   state <= ST_IDLE;
      endcase
    end
  end

  udp_txbuf_ram #(.AWIDTH(AWIDTH)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (txbuf_ce),
    .raddr (txbuf_addr),
    .rdata (txbuf_rdata)
  );

endmodule
